// File: rtl/polar_dec_pkg.sv
// polar_dec_pkg
// Shared types and helpers for the SC polar decoder schedule controller.
//   state_t      : controller FSM states (IDLE encodes as zero).
//   op_t         : PE operation type, f or g.
//   ctz()        : count trailing zeros; selects the first stage of a bit's walk.
//   region_base(): base address of a stage's region in the intermediate RAM.
//   stage_beats(): number of beats a stage needs with a given lane count.
package polar_dec_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_STAGE_OP  = 3'd1,
        ST_FROZEN_RD = 3'd2,
        ST_DECIDE    = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    typedef enum logic {
        OP_F = 1'b0,
        OP_G = 1'b1
    } op_t;

    // Returns 0 for x==0; callers only use it for non-zero bit indices.
    function automatic int ctz(input logic [31:0] x);
        int cnt;
        cnt = 0;
        for (int k = 31; k >= 0; k--) begin
            if (x[k]) cnt = k;
        end
        return cnt;
    endfunction

    // Stage s writes 2^s LLRs starting at address 2^s; address 0 is never used.
    function automatic int unsigned region_base(input int unsigned s);
        return 32'd1 << s;
    endfunction

    function automatic int unsigned stage_beats(input int unsigned s, input int unsigned p);
        return ((32'd1 << s) + p - 32'd1) / p;
    endfunction

endpackage

// File: rtl/polar_stage_start.sv
// polar_stage_start
// Combinational helper: for a bit index i, gives the stage where its LLR-tree
// walk begins and whether that first stage is a g operation.
//   bit_idx     : bit index i
//   start_stage : n-1 for i==0, otherwise ctz(i)
//   first_op    : OP_F for i==0, otherwise OP_G
module polar_stage_start
    import polar_dec_pkg::*;
#(
    parameter int LOG_N   = 10,
    parameter int STAGE_W = 4
) (
    input  logic [LOG_N-1:0]   bit_idx,
    output logic [STAGE_W-1:0] start_stage,
    output op_t                first_op
);

    always_comb begin
        start_stage = STAGE_W'(LOG_N - 1);
        first_op    = OP_F;
        if (bit_idx != '0) begin
            start_stage = STAGE_W'(ctz(32'(bit_idx)));
            first_op    = OP_G;
        end
    end

endmodule

// File: rtl/polar_sc_schedule_ctrl.sv
// polar_sc_schedule_ctrl
// Successive-cancellation schedule controller. For every bit i it walks the LLR
// tree from its start stage down to stage 0, issuing P-lane f/g beats with read
// and write addresses, then reads the frozen flag and issues a decision request.
//
// Handshakes: a beat (op_*) or a decision request (dec_*) transfers on the rising
// edge where valid && ready. While valid is high and ready is low every field of
// that channel holds; valid never drops before the transfer. All outputs are
// decoded from registers only, so ready never reaches an output combinationally.
//
// Ports:
//   clk, reset (async, active low), start (accepted in IDLE only)
//   busy            : controller is not in IDLE
//   op_valid/ready  : f/g beat channel; op_is_g, op_stage, op_src_sel,
//                     op_rd_addr (lane-0 operand a), op_wr_addr, op_lane_mask,
//                     op_last (stage-0 beat of the current bit)
//   frozen_rd_addr  : frozen RAM address (held at i), frozen_data returned 1 cycle later
//   dec_valid/ready : decision channel; dec_frozen, dec_bit_idx
//   done            : one-cycle pulse after the last bit's decision
//   dbg_state       : current FSM state
module polar_sc_schedule_ctrl
    import polar_dec_pkg::*;
#(
    parameter  int CODE_LENGTH = 1024,
    parameter  int PE_NUM      = 4,
    localparam int LOG_N       = $clog2(CODE_LENGTH),
    localparam int STAGE_W     = $clog2(LOG_N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               op_valid,
    input  logic               op_ready,
    output logic               op_is_g,
    output logic [STAGE_W-1:0] op_stage,
    output logic               op_src_sel,
    output logic [LOG_N-1:0]   op_rd_addr,
    output logic [LOG_N-1:0]   op_wr_addr,
    output logic [PE_NUM-1:0]  op_lane_mask,
    output logic               op_last,
    output logic [LOG_N-1:0]   frozen_rd_addr,
    input  logic               frozen_data,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic               dec_frozen,
    output logic [LOG_N-1:0]   dec_bit_idx,
    output logic               done,
    output state_t             dbg_state
);

    state_t               state_q, state_d;
    logic [LOG_N-1:0]     bit_q, bit_d;
    logic [STAGE_W-1:0]   stage_q, stage_d;
    logic [LOG_N-1:0]     j_q, j_d;
    op_t                  op_q, op_d;
    logic                 frz_q;

    logic [LOG_N-1:0]     ss_idx;
    logic [STAGE_W-1:0]   ss_stage;
    op_t                  ss_op;
    logic [LOG_N:0]       stage_size;
    logic [LOG_N:0]       up_base;
    logic                 last_beat;

    // Start stage of the bit about to be walked: 0 when leaving IDLE, i+1 after a decision.
    polar_stage_start #(
        .LOG_N   (LOG_N),
        .STAGE_W (STAGE_W)
    ) u_stage_start (
        .bit_idx     (ss_idx),
        .start_stage (ss_stage),
        .first_op    (ss_op)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            bit_q   <= '0;
            stage_q <= '0;
            j_q     <= '0;
            op_q    <= OP_F;
            frz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            stage_q <= stage_d;
            j_q     <= j_d;
            op_q    <= op_d;
            // frozen_rd_addr has been at i since the walk began, so the RAM
            // output during FROZEN_RD already belongs to bit i.
            if (state_q == ST_FROZEN_RD) frz_q <= frozen_data;
        end
    end

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        stage_d = stage_q;
        j_d     = j_q;
        op_d    = op_q;
        ss_idx  = (state_q == ST_IDLE) ? '0 : bit_q + LOG_N'(1);

        op_valid       = 1'b0;
        op_is_g        = 1'b0;
        op_stage       = '0;
        op_src_sel     = 1'b0;
        op_rd_addr     = '0;
        op_wr_addr     = '0;
        op_lane_mask   = '0;
        op_last        = 1'b0;
        frozen_rd_addr = '0;
        dec_valid      = 1'b0;
        dec_frozen     = 1'b0;
        dec_bit_idx    = '0;
        done           = 1'b0;
        busy           = (state_q != ST_IDLE);
        dbg_state      = state_q;

        stage_size = (LOG_N+1)'(region_base(32'(stage_q)));
        up_base    = stage_size << 1;
        // Final beat of a stage once the lanes cover the remaining 2^s outputs.
        last_beat  = ({1'b0, j_q} + (LOG_N+1)'(PE_NUM)) >= stage_size;

        if (state_q != ST_IDLE) frozen_rd_addr = bit_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_STAGE_OP;
                    bit_d   = '0;
                    stage_d = ss_stage;
                    op_d    = ss_op;
                    j_d     = '0;
                end
            end
            ST_STAGE_OP: begin
                op_valid   = 1'b1;
                op_is_g    = (op_q == OP_G);
                op_stage   = stage_q;
                op_last    = (stage_q == '0);
                op_wr_addr = stage_size[LOG_N-1:0] + j_q;
                // The top stage reads channel LLRs; lower stages read the parent region.
                if (stage_q == STAGE_W'(LOG_N - 1)) begin
                    op_src_sel = 1'b0;
                    op_rd_addr = j_q;
                end else begin
                    op_src_sel = 1'b1;
                    op_rd_addr = up_base[LOG_N-1:0] + j_q;
                end
                if (stage_size >= (LOG_N+1)'(PE_NUM)) op_lane_mask = '1;
                else op_lane_mask = (PE_NUM'(1) << stage_size) - PE_NUM'(1);

                if (op_ready) begin
                    if (!last_beat) begin
                        j_d = j_q + LOG_N'(PE_NUM);
                    end else if (stage_q == '0) begin
                        j_d     = '0;
                        state_d = ST_FROZEN_RD;
                    end else begin
                        j_d     = '0;
                        stage_d = stage_q - STAGE_W'(1);
                        op_d    = OP_F;
                    end
                end
            end
            ST_FROZEN_RD: begin
                state_d = ST_DECIDE;
            end
            ST_DECIDE: begin
                dec_valid   = 1'b1;
                dec_frozen  = frz_q;
                dec_bit_idx = bit_q;
                if (dec_ready) begin
                    if (bit_q == LOG_N'(CODE_LENGTH - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_STAGE_OP;
                        bit_d   = bit_q + LOG_N'(1);
                        stage_d = ss_stage;
                        op_d    = ss_op;
                        j_d     = '0;
                    end
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
